xbus_fifo_mailbox: RTL
======================

XBUS_FIFO_MAILBOX -- requirements
Module: xbus_fifo_mailbox

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 4..256.
REQ-002 Parameter THRESH_RST, default 8, reset value of the IRQ level threshold.
REQ-003 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-004 RES  in  1  reset, asynchronous and active-high.
REQ-005 XDREQ  in  1  bus request, already chip-selected by the top-level decoder; held by the master until XDACK.
REQ-006 XRD / XWR  in  1 each  read / write qualifier, valid with XDREQ.
REQ-007 XBE  in  4  byte enables for writes.
REQ-008 XADDR  in  32  byte address; only XADDR[3:2] decoded.
REQ-009 XATAI  in  32  write data.
REQ-010 XATAO  out  32  read data, valid while XDACK=1.
REQ-011 XDACK  out  1  one-cycle transfer acknowledge.
REQ-012 XIRQ  out  1  level interrupt (see Configuration).

Function
REQ-013 Register map by XADDR[3:2]: 0 DATA (write=push, read=pop), 1 STATUS (read-only), 2 CTRL (R/W), 3 FLAGS (read, write-1-to-clear).
REQ-014 Bus FSM states IDLE, ACK; IDLE->ACK when XDREQ=1 and (XRD or XWR); ACK->IDLE unconditionally.
REQ-015 XDACK=1 exactly in ACK; access latency: one cycle from request to acknowledge.
REQ-016 Side effects (push, pop, CTRL write, flag clear) occur once, on the IDLE->ACK edge; XATAO is registered on that same edge.
REQ-017 XATAO=0 whenever XDACK=0.
REQ-018 Push stores XATAI with bytes whose XBE bit is 0 forced to 0x00.
REQ-019 Push when full: data discarded, pointers unchanged, FLAGS[0] OVF set (sticky).
REQ-020 Pop when empty: XATAO=0, pointers unchanged, FLAGS[1] UNF set (sticky).
REQ-021 Pointers wrap modulo DEPTH; COUNT width log2(DEPTH)+1, range 0..DEPTH.
REQ-022 STATUS = {8'h0, THRESH[7:0], 6'h0, FULL, EMPTY, COUNT zero-extended to 8 bits} in bits [31:24],[23:16],[15:10],[9],[8],[7:0].
REQ-023 CTRL bit0 CLEAR: writing 1 with XBE[0]=1 empties the FIFO in the same edge; bit self-clears and reads back 0.
REQ-024 CTRL bits[15:8] THRESH: written when XBE[1]=1; reads back the stored value.
REQ-025 CTRL write with both push-clear semantics is not possible (distinct addresses); flags clear and set on the same edge cannot occur.
REQ-026 XRD and XWR both 1: treated as write.
REQ-027 FLAGS write: each bit written as 1 with XBE[0]=1 clears that flag.

Reset
REQ-028 RES=1 asynchronously forces FSM=IDLE, XDACK=0, XATAO=0, XIRQ=0, pointers and COUNT=0, flags=0, THRESH=THRESH_RST, IRQ enable=0.
REQ-029 RES asserted during ACK aborts the transfer; no acknowledge is issued after RES is released for that request unless XDREQ is still high, in which case it is served as a new request.
REQ-030 FIFO storage contents are not reset; they are unobservable while EMPTY=1.

Configuration
REQ-031 Macro XFIFO_IRQ_EN defined: CTRL bit1 IEN exists; XIRQ = IEN and (COUNT >= THRESH or OVF), registered, one cycle after the causing edge.
REQ-032 Macro XFIFO_IRQ_EN undefined: XIRQ tied 0, CTRL bit1 reads 0 and ignores writes; all other behaviour identical.

Verification
REQ-033 Reset, then read STATUS -> XDACK one cycle after XDREQ, XATAO=0x0008_0100 (THRESH 8, EMPTY, COUNT 0).
REQ-034 Push 0x11223344 with XBE=4'b0101, pop -> XATAO=0x00220044, then STATUS EMPTY=1.
REQ-035 Push 17 words with DEPTH=16 -> FULL=1, COUNT=16, OVF=1; 16 pops return words 1..16 in order; 17th pop returns 0 and sets UNF.
REQ-036 XFIFO_IRQ_EN defined, CTRL=0x0000_0402 (THRESH 4, IEN) -> XIRQ rises one cycle after 4th push, falls one cycle after next pop.
REQ-037 Write CTRL bit0 with 5 entries queued -> COUNT=0 next read; write FLAGS 0x3 -> OVF/UNF clear.
REQ-038 Assert RES during ACK of a pop with XDREQ held -> XDACK=0 immediately; after release exactly one new acknowledge, pointers reset.

Source files
------------

// File: rtl/xbus_fifo_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : xbus_fifo_mailbox
// Description : XBUS slave mailbox. A DEPTH-entry FIFO is pushed and popped
//               through the DATA register. STATUS, CTRL and sticky FLAGS sit
//               alongside it. Every access is acknowledged after exactly one
//               cycle.
//               Optional macro XFIFO_IRQ_EN adds a level interrupt on
//               COUNT >= THRESH or OVF.
// Revision    : 1.0 - initial release
// ============================================================================
module xbus_fifo_mailbox #(
  parameter int DEPTH      = 16,
  parameter int THRESH_RST = 8
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        XDREQ,
  input  logic        XRD,
  input  logic        XWR,
  input  logic [3:0]  XBE,
  input  logic [31:0] XADDR,
  input  logic [31:0] XATAI,
  output logic [31:0] XATAO,
  output logic        XDACK,
  output logic        XIRQ
);

  localparam int              AW           = $clog2(DEPTH);
  localparam logic [AW-1:0]   c_ptr_one    = AW'(1);
  localparam logic [AW:0]     c_cnt_one    = (AW+1)'(1);
  localparam logic [AW:0]     c_cnt_full   = (AW+1)'(DEPTH);
  localparam logic [7:0]      c_thresh_rst = 8'(THRESH_RST);

  localparam logic [1:0]      c_reg_data   = 2'd0;
  localparam logic [1:0]      c_reg_status = 2'd1;
  localparam logic [1:0]      c_reg_ctrl   = 2'd2;
  localparam logic [1:0]      c_reg_flags  = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_start;

  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic [7:0]      r_thresh;
  logic            r_ovf;
  logic            r_unf;
  logic [31:0]     r_rdata;

  logic            w_wr;
  logic            w_rd;
  logic [1:0]      w_sel;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_pop_ok;
  logic            w_clear;
  logic            w_ctrl_wr;
  logic            w_flags_wr;
  logic            w_ien;
  logic [31:0]     w_wdata;
  logic [31:0]     w_rdval;

  // Only XADDR[3:2] is decoded; the rest is deliberately ignored.
  logic            w_unused_addr;
  assign w_unused_addr = ^{XADDR[31:4], XADDR[1:0]};

  // A simultaneous read and write qualifier is treated as a write.
  assign w_wr       = XWR;
  assign w_rd       = XRD & ~XWR;
  assign w_sel      = XADDR[3:2];
  assign w_full     = (r_count == c_cnt_full);
  assign w_empty    = (r_count == '0);

  assign w_push     = w_start & w_wr & (w_sel == c_reg_data);
  assign w_pop      = w_start & w_rd & (w_sel == c_reg_data);
  assign w_push_ok  = w_push & ~w_full;
  assign w_pop_ok   = w_pop & ~w_empty;
  assign w_ctrl_wr  = w_start & w_wr & (w_sel == c_reg_ctrl);
  assign w_flags_wr = w_start & w_wr & (w_sel == c_reg_flags);
  assign w_clear    = w_ctrl_wr & XBE[0] & XATAI[0];

  // Bytes without an enable are stored as zero.
  assign w_wdata = {XBE[3] ? XATAI[31:24] : 8'h00,
                    XBE[2] ? XATAI[23:16] : 8'h00,
                    XBE[1] ? XATAI[15:8]  : 8'h00,
                    XBE[0] ? XATAI[7:0]   : 8'h00};

  // Bus state register; an asserted reset aborts any transfer in flight.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: accept a qualified request in IDLE, acknowledge for one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (XDREQ && (XRD || XWR)) begin
          w_state_nxt = ACK;
          w_start     = 1'b1;
        end
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign XDACK = (r_state == ACK);

  // Read mux; a pop from an empty FIFO returns zero.
  always_comb begin
    w_rdval = 32'h0;
    case (w_sel)
      c_reg_data:   w_rdval = w_empty ? 32'h0 : r_mem[r_rptr];
      c_reg_status: w_rdval = {8'h00, r_thresh, 6'h00, w_full, w_empty, 8'(r_count)};
      c_reg_ctrl:   w_rdval = {16'h0000, r_thresh, 6'h00, w_ien, 1'b0};
      c_reg_flags:  w_rdval = {30'h0, r_unf, r_ovf};
      default:      w_rdval = 32'h0;
    endcase
  end

  // Read data is captured on the accept edge and held only through ACK.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES)                 r_rdata <= 32'h0;
    else if (w_start & w_rd) r_rdata <= w_rdval;
    else                     r_rdata <= 32'h0;
  end

  assign XATAO = r_rdata;

  // FIFO storage has no reset; stale entries are invisible while empty.
  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_wptr] <= w_wdata;
  end

  // Pointers and occupancy; CLEAR empties the FIFO on the accept edge.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_push_ok) begin
      r_wptr  <= r_wptr + c_ptr_one;
      r_count <= r_count + c_cnt_one;
    end else if (w_pop_ok) begin
      r_rptr  <= r_rptr + c_ptr_one;
      r_count <= r_count - c_cnt_one;
    end
  end

  // Threshold register and sticky overflow/underflow flags (write-1-to-clear).
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_thresh <= c_thresh_rst;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_ctrl_wr && XBE[1])            r_thresh <= XATAI[15:8];
      if (w_push && w_full)               r_ovf    <= 1'b1;
      else if (w_flags_wr && XBE[0] && XATAI[0]) r_ovf <= 1'b0;
      if (w_pop && w_empty)               r_unf    <= 1'b1;
      else if (w_flags_wr && XBE[0] && XATAI[1]) r_unf <= 1'b0;
    end
  end

`ifdef XFIFO_IRQ_EN
  logic r_ien;
  logic r_irq;

  // Interrupt enable bit held in CTRL[1].
  always_ff @(posedge CLK or posedge RES) begin
    if (RES)                      r_ien <= 1'b0;
    else if (w_ctrl_wr && XBE[0]) r_ien <= XATAI[1];
  end

  // Level interrupt registered from the state left by the previous edge.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) r_irq <= 1'b0;
    else     r_irq <= r_ien & ((9'(r_count) >= {1'b0, r_thresh}) | r_ovf);
  end

  assign w_ien = r_ien;
  assign XIRQ  = r_irq;
`else
  assign w_ien = 1'b0;
  assign XIRQ  = 1'b0;
`endif

endmodule
`default_nettype wire
